// File: rtl/ysyx_22041207_ifu_if.sv
// Instruction-memory port of the fetch unit.
// Handshake rules, one place for all of them:
//   - A request transfers on a rising edge where req_valid && req_ready.
//   - At most one request is outstanding at a time.
//   - Every accepted request gets exactly one response, in a later cycle,
//     marked by a single-cycle rsp_valid pulse. Responses cannot be back-pressured.
interface ysyx_22041207_ifu_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    // Fetch unit side
    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // Memory side
    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time
// and holds the fetched instruction in a single registered slot for IF/ID.
// Redirects flush the slot and turn any in-flight fetch into a discarded one.
module ysyx_22041207_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [63:0]               redirect_pc,
    ysyx_22041207_ifu_if.master       imem,
    output logic [31:0]               inst,
    output logic [63:0]               pc,
    output logic                      inst_valid,
    output logic [1:0]                dbg_state
);

    // IDLE: just out of reset; REQ: presenting fetch_pc; WAIT: awaiting our
    // response; DROP: awaiting a stale response that must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [63:0] fetch_pc, fetch_pc_n;
    logic [31:0] inst_n;
    logic [63:0] pc_n;
    logic        inst_valid_n;

    logic consume;
    logic slot_free;
    logic req_fire;
    logic unused_rpc_lo;

    // The two low bits of the redirect target are forced to zero.
    assign unused_rpc_lo = ^redirect_pc[1:0];

    // Requests only go out when the slot will be empty by the time the
    // response lands, so the response never needs a skid buffer.
    assign consume        = inst_valid && !stall;
    assign slot_free      = !inst_valid || !stall;
    assign imem.req_valid = (state == REQ) && slot_free;
    assign imem.addr      = fetch_pc;
    assign req_fire       = imem.req_valid && imem.req_ready;
    assign dbg_state      = state;

    // Next-state, next fetch PC and next slot contents; redirect wins over all.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        inst_n       = inst;
        pc_n         = pc;
        inst_valid_n = inst_valid;

        if (redirect) begin
            inst_n       = NOP_INST;
            pc_n         = '0;
            inst_valid_n = 1'b0;
            fetch_pc_n   = {redirect_pc[63:2], 2'b00};
            case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = req_fire ? DROP : REQ;
                WAIT:    state_n = imem.rsp_valid ? REQ : DROP;
                DROP:    state_n = imem.rsp_valid ? REQ : DROP;
                default: state_n = REQ;
            endcase
        end else begin
            if (consume) begin
                inst_n       = NOP_INST;
                pc_n         = '0;
                inst_valid_n = 1'b0;
            end
            case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (req_fire) state_n = WAIT;
                end
                WAIT: begin
                    if (imem.rsp_valid) begin
                        inst_n       = imem.rsp_data;
                        pc_n         = fetch_pc;
                        inst_valid_n = 1'b1;
                        fetch_pc_n   = fetch_pc + 64'd4;
                        state_n      = REQ;
                    end
                end
                DROP: begin
                    if (imem.rsp_valid) state_n = REQ;
                end
                default: state_n = REQ;
            endcase
        end
    end

    // State, fetch PC and output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            inst       <= NOP_INST;
            pc         <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            inst       <= inst_n;
            pc         <= pc_n;
            inst_valid <= inst_valid_n;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Bench for the fetch unit: directed scenarios followed by a randomized run
// against a PC-stream model (sequential +4, jump to aligned target on redirect).
module tb_ysyx_22041207_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_valid;
    logic [1:0]  dbg_state;

    ysyx_22041207_ifu_if imem_bus ();

    ysyx_22041207_ifu dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .dbg_state   (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Memory model state for the randomized run
    logic [63:0] rsp_q[$];
    int          rsp_wait;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic st, input logic rdr, input logic [63:0] rpc);
        tick();
        imem_bus.req_ready = rdy;
        imem_bus.rsp_valid = rv;
        imem_bus.rsp_data  = rd;
        stall              = st;
        redirect           = rdr;
        redirect_pc        = rpc;
        #1;
    endtask

    task automatic apply_reset();
        rst                = 1'b1;
        stall              = 1'b0;
        redirect           = 1'b0;
        redirect_pc        = '0;
        imem_bus.req_ready = 1'b0;
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rsp_data  = '0;
        rsp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        n_assert++;
        if ({imem_bus.req_valid, inst_valid, inst, pc, dbg_state} !== {1'b0, 1'b0, NOP_INST, 64'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got rv=%b v=%b inst=%h pc=%h st=%0d, expected 0 0 %h 0 0",
                     imem_bus.req_valid, inst_valid, inst, pc, dbg_state, NOP_INST);
        end
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if (imem_bus.req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_cycle: got req_valid=%b expected 0", imem_bus.req_valid);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({imem_bus.req_valid, imem_bus.addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL reset_first_req: got rv=%b addr=%h expected 1 %h",
                     imem_bus.req_valid, imem_bus.addr, RESET_PC);
        end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({imem_bus.req_valid, imem_bus.addr, inst_valid} !== {1'b1, 64'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_req0: got rv=%b addr=%h v=%b expected 1 80000000 0",
                     imem_bus.req_valid, imem_bus.addr, inst_valid);
        end
        drive(1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if (imem_bus.req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_wait_noreq: got rv=%b expected 0", imem_bus.req_valid);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, pc, imem_bus.req_valid, imem_bus.addr} !==
            {1'b1, 32'h0000_0093, 64'h8000_0000, 1'b1, 64'h8000_0004}) begin
            n_fail++;
            $display("FAIL basic_slot0: got v=%b inst=%h pc=%h rv=%b addr=%h expected 1 00000093 80000000 1 80000004",
                     inst_valid, inst, pc, imem_bus.req_valid, imem_bus.addr);
        end
        drive(1'b1, 1'b1, 32'h0010_0113, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, pc} !== {1'b0, NOP_INST, 64'h0}) begin
            n_fail++;
            $display("FAIL basic_gap: got v=%b inst=%h pc=%h expected 0 %h 0", inst_valid, inst, pc, NOP_INST);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, pc} !== {1'b1, 32'h0010_0113, 64'h8000_0004}) begin
            n_fail++;
            $display("FAIL basic_slot1: got v=%b inst=%h pc=%h expected 1 00100113 80000004", inst_valid, inst, pc);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b1, 32'h00A0_0193, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
            n_assert++;
            if ({imem_bus.req_valid, inst_valid, inst, pc} !== {1'b0, 1'b1, 32'h00A0_0193, 64'h8000_0000}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got rv=%b v=%b inst=%h pc=%h expected 0 1 00a00193 80000000",
                         i, imem_bus.req_valid, inst_valid, inst, pc);
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({imem_bus.req_valid, imem_bus.addr} !== {1'b1, 64'h8000_0004}) begin
            n_fail++;
            $display("FAIL stall_release: got rv=%b addr=%h expected 1 80000004", imem_bus.req_valid, imem_bus.addr);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1002);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({imem_bus.req_valid, inst_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL redir_wait_drop: got rv=%b v=%b expected 0 0", imem_bus.req_valid, inst_valid);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, imem_bus.req_valid, imem_bus.addr} !== {1'b0, NOP_INST, 1'b1, 64'h8000_1000}) begin
            n_fail++;
            $display("FAIL redir_wait_target: got v=%b inst=%h rv=%b addr=%h expected 0 %h 1 80001000",
                     inst_valid, inst, imem_bus.req_valid, imem_bus.addr, NOP_INST);
        end
    endtask

    task automatic test_redirect_rsp();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h8000_2000);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, pc, imem_bus.req_valid, imem_bus.addr} !==
            {1'b0, NOP_INST, 64'h0, 1'b1, 64'h8000_2000}) begin
            n_fail++;
            $display("FAIL redir_rsp: got v=%b inst=%h pc=%h rv=%b addr=%h expected 0 %h 0 1 80002000",
                     inst_valid, inst, pc, imem_bus.req_valid, imem_bus.addr, NOP_INST);
        end
    endtask

    task automatic test_redirect_handshake();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_3004);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if (imem_bus.req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_hs_owed: got rv=%b expected 0", imem_bus.req_valid);
        end
        drive(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, imem_bus.req_valid, imem_bus.addr} !== {1'b0, 1'b1, 64'h8000_3004}) begin
            n_fail++;
            $display("FAIL redir_hs_target: got v=%b rv=%b addr=%h expected 0 1 80003004",
                     inst_valid, imem_bus.req_valid, imem_bus.addr);
        end
        drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({inst_valid, inst, pc} !== {1'b1, 32'h2222_2222, 64'h8000_3004}) begin
            n_fail++;
            $display("FAIL redir_hs_load: got v=%b inst=%h pc=%h expected 1 22222222 80003004", inst_valid, inst, pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
            n_assert++;
            if ({imem_bus.req_valid, imem_bus.addr} !== {1'b1, RESET_PC}) begin
                n_fail++;
                $display("FAIL notready_hold[%0d]: got rv=%b addr=%h expected 1 %h",
                         i, imem_bus.req_valid, imem_bus.addr, RESET_PC);
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        #1;
        rst = 1'b1;
        #1;
        n_assert++;
        if ({imem_bus.req_valid, inst_valid, inst, pc, dbg_state} !== {1'b0, 1'b0, NOP_INST, 64'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got rv=%b v=%b inst=%h pc=%h st=%0d expected 0 0 %h 0 0",
                     imem_bus.req_valid, inst_valid, inst, pc, dbg_state, NOP_INST);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_assert++;
        if ({imem_bus.req_valid, imem_bus.addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL reset_resume: got rv=%b addr=%h expected 1 %h", imem_bus.req_valid, imem_bus.addr, RESET_PC);
        end
    endtask

    // Randomized run: memory with random ready and 1..4 cycle latency, random
    // stalls and redirects; every consumed slot must follow the PC stream.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] tgt;
        logic        st, rdr;
        int          consumed;
        exp_pc   = RESET_PC;
        consumed = 0;
        apply_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            st  = ($urandom_range(0, 3) == 0);
            rdr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else                           tgt = {32'h0, 16'h8000, 16'($urandom)};
            tick();
            stall              = st;
            redirect           = rdr;
            redirect_pc        = tgt;
            imem_bus.rsp_valid = 1'b0;
            imem_bus.rsp_data  = $urandom;
            if (rsp_q.size() != 0) begin
                if (rsp_wait == 0) begin
                    imem_bus.rsp_valid = 1'b1;
                    imem_bus.rsp_data  = mem_word(rsp_q.pop_front());
                end else begin
                    rsp_wait--;
                end
            end
            imem_bus.req_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_assert++;
            if (!inst_valid && ({inst, pc} !== {NOP_INST, 64'h0})) begin
                n_fail++;
                $display("FAIL rnd_empty_slot: cyc %0d inst=%h pc=%h expected %h 0", cyc, inst, pc, NOP_INST);
            end
            n_assert++;
            if (imem_bus.req_valid && ((inst_valid && st) || rsp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_req_gate: cyc %0d req_valid=1 with v=%b stall=%b owed=%0d expected 0",
                         cyc, inst_valid, st, rsp_q.size());
            end
            if (inst_valid && !st && !rdr) begin
                n_assert++;
                if ({pc, inst} !== {exp_pc, mem_word(exp_pc)}) begin
                    n_fail++;
                    $display("FAIL rnd_stream: cyc %0d pc=%h inst=%h expected %h %h",
                             cyc, pc, inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            if (rdr) exp_pc = {tgt[63:2], 2'b00};
            if (imem_bus.req_valid && imem_bus.req_ready) begin
                rsp_q.push_back(imem_bus.addr);
                rsp_wait = $urandom_range(0, 3);
            end
        end
        n_assert++;
        if (consumed < 200) begin
            n_fail++;
            $display("FAIL rnd_throughput: consumed %0d expected at least 200", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_handshake();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_ifu.md
# ysyx_22041207_ifu

Instruction fetch unit. Owns the architectural fetch PC and issues one-at-a-time word reads to instruction memory over a valid/ready request and valid-only response handshake. It presents the fetched instruction and its PC through a single registered output slot that feeds the IF/ID pipeline register. Branch/jump redirects flush the slot and discard any in-flight fetch; downstream stalls hold the slot.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction driven while slot empty (addi x0,x0,0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  downstream (IF/ID bubble) not accepting; slot held
- redirect  in  1  control-flow redirect from execute; same cycle IF/ID is flushed
- redirect_pc  in  64  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  64  fetch address (= fetch_pc)
- imem_rsp_valid  in  1  response data valid, exactly one per accepted request, no backpressure
- imem_rsp_data  in  32  fetched instruction word
- inst  out  32  slot instruction; NOP_INST when inst_valid=0
- pc  out  64  slot PC; 0 when inst_valid=0
- inst_valid  out  1  slot holds a live instruction

## Operation
- Registers: fetch_pc (64), state, slot {inst, pc, inst_valid}.
- States: IDLE, REQ, WAIT, DROP.
- Slot consumed at an edge where inst_valid=1 and stall=0; slot "free" when inst_valid=0 or being consumed.
- imem_req_valid = (state==REQ) && slot free; imem_addr = fetch_pc.
- IDLE -> REQ unconditionally (only entered from reset).
- REQ: on imem_req_valid && imem_req_ready -> WAIT; else stay.
- WAIT: on imem_rsp_valid -> load slot {imem_rsp_data, fetch_pc, 1}, fetch_pc <= fetch_pc+4 (mod 2^64), -> REQ.
- DROP: on imem_rsp_valid -> discard data, -> REQ.
- Slot consumed and not reloaded: inst <= NOP_INST, pc <= 0, inst_valid <= 0.
- At most one request outstanding; because requests issue only when the slot is free, the slot is always free when the response returns (no skid buffer).
- Redirect (highest priority, overrides stall and everything else): slot <= {NOP_INST, 0, 0}; fetch_pc <= {redirect_pc[63:2], 2'b00}; next state:
  - REQ with request handshake this cycle -> DROP (old-address request in flight).
  - REQ without handshake -> REQ (new address presented next cycle).
  - WAIT with imem_rsp_valid this cycle -> REQ (response discarded).
  - WAIT without response -> DROP.
  - DROP -> DROP (response still owed; discarded when it arrives, unless it arrives this cycle -> REQ).
  - IDLE -> REQ.
- imem_addr may change while imem_req_valid=1 and imem_req_ready=0 only in the cycle after a redirect; otherwise stable until handshake.

## Timing
- Reset (async assert): state=IDLE, fetch_pc=RESET_PC, inst=NOP_INST, pc=0, inst_valid=0, imem_req_valid=0. Reset mid-fetch abandons the outstanding response; memory is reset by the same rst.
- First imem_req_valid=1 in the first full cycle after rst deasserts (IDLE->REQ edge).
- Latency: request accepted cycle t, response cycle t+k (k>=1), inst_valid=1 from cycle t+k+1; next request earliest cycle t+k+1.
- Zero-wait memory (ready=1, k=1): one instruction every 2 cycles.
- Stall with slot full blocks new requests; an in-flight fetch still completes (slot was free at issue).
- Redirect target first requested the cycle after redirect (REQ) or the cycle after the stale response (DROP).

## Test plan
- Reset release, ready=1, 1-cycle response of 0x00000093 then 0x00100113 -> imem_addr 0x80000000 then 0x80000004; inst/pc = 0x00000093/0x80000000 then 0x00100113/0x80000004, inst_valid pulses every 2 cycles.
- Slot full, stall=1 held 5 cycles -> imem_req_valid=0, inst/pc/inst_valid stable; stall drops -> request for next PC same cycle.
- Redirect to 0x80001002 while in WAIT; stale response 0xDEADBEEF arrives 3 cycles later -> discarded, inst_valid=0, next request at 0x80001000.
- Redirect same cycle as imem_rsp_valid -> data discarded, next request at target, no slot load.
- Redirect same cycle as request handshake -> DROP; stale response dropped; then fetch target.
- imem_req_ready=0 for 4 cycles, rst asserted mid-WAIT -> outputs immediately at reset values; fetch resumes at 0x80000000.
